// File: rtl/bfp_calc_seq.sv
// bfp_calc_seq: sequential body-fat-percentage calculator.
// BMI = weight*10000 / height^2 (truncating), then
// BFP = (120*BMI + 23*age - OFF) / 100, both by restoring radix-2 division.
// Optional feature macro: BFP_ROUND_EN (round-half-up on the BFP divide).
module bfp_calc_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sex,
    input  logic [W-1:0] weight,
    input  logic [W-1:0] height,
    input  logic [W-1:0] age,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] bfp,
    output logic [W-1:0] bmi,
    output logic         sat,
    output logic         err
);

    localparam int QW  = W + 14;                 // BMI numerator / shared quotient width
    localparam int PW  = W + 8;                  // BFP numerator width
    localparam int NW  = W + 9;                  // signed N width
    localparam int RMW = (2 * W > 7) ? 2 * W : 7; // remainder / divisor width
    localparam int CW  = $clog2(QW);

`ifdef BFP_ROUND_EN
    localparam logic [PW-1:0] RND = PW'(50);
`else
    localparam logic [PW-1:0] RND = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SQ, S_DIVB, S_CALC, S_DIVP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sex_q, sex_d;
    logic [W-1:0]    weight_q, weight_d, height_q, height_d, age_q, age_d;
    logic [RMW-1:0]  rem_q, rem_d, dvs_q, dvs_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [W-1:0]    bmiw_q, bmiw_d;
    logic            bsat_q, bsat_d;
    logic [NW-1:0]   n_q, n_d;
    logic [W-1:0]    bfp_q, bfp_d, bmi_q, bmi_d;
    logic            sat_q, sat_d, err_q, err_d;

    logic [RMW:0]    rem_sh;
    logic            take;
    logic [RMW-1:0]  rem_nx;
    logic [QW-1:0]   quo_nx;
    logic [2*W-1:0]  h2;
    logic [NW-1:0]   off_w, sum_w;
    logic [PW-1:0]   num_p;

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign bfp       = bfp_q;
    assign bmi       = bmi_q;
    assign sat       = sat_q;
    assign err       = err_q;

    // Shared divider step, squaring, N arithmetic and next-state/datapath selection
    always_comb begin
        rem_sh = {rem_q, quo_q[QW-1]};
        take   = (rem_sh >= {1'b0, dvs_q});
        rem_nx = take ? RMW'(rem_sh - {1'b0, dvs_q}) : rem_q[RMW-1:0] << 1 | RMW'(quo_q[QW-1]);
        quo_nx = {quo_q[QW-2:0], take};
        h2     = {{W{1'b0}}, height_q} * {{W{1'b0}}, height_q};
        off_w  = sex_q ? NW'(1620) : NW'(540);
        sum_w  = NW'(120) * NW'(bmiw_q) + NW'(23) * NW'(age_q);
        num_p  = n_q[PW-1:0] + RND;

        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        sex_d    = sex_q;
        weight_d = weight_q;
        height_d = height_q;
        age_d    = age_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        bmiw_d   = bmiw_q;
        bsat_d   = bsat_q;
        n_d      = n_q;
        bfp_d    = bfp_q;
        bmi_d    = bmi_q;
        sat_d    = sat_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sex_d    = sex;
                    weight_d = weight;
                    height_d = height;
                    age_d    = age;
                    state_d  = S_SQ;
                end
            end
            S_SQ: begin
                if (height_q == '0) begin
                    bfp_d   = '0;
                    bmi_d   = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dvs_d   = RMW'(h2);
                    rem_d   = '0;
                    quo_d   = QW'(weight_q) * QW'(10000);
                    cnt_d   = '0;
                    bsat_d  = 1'b0;
                    state_d = S_DIVB;
                end
            end
            S_DIVB: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    if (|quo_nx[QW-1:W]) begin
                        bmiw_d = '1;
                        bsat_d = 1'b1;
                    end else begin
                        bmiw_d = quo_nx[W-1:0];
                    end
                    phase_d = 2'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Phase 0 registers N, phase 1 branches on its sign; the
                // negative branch spends a third cycle committing the clamp.
                case (phase_q)
                    2'd0: begin
                        n_d     = sum_w - off_w;
                        phase_d = 2'd1;
                    end
                    2'd1: begin
                        if (n_q[NW-1]) begin
                            phase_d = 2'd2;
                        end else begin
                            rem_d   = '0;
                            dvs_d   = RMW'(100);
                            quo_d   = {num_p, {(QW - PW){1'b0}}};
                            cnt_d   = '0;
                            state_d = S_DIVP;
                        end
                    end
                    default: begin
                        bfp_d   = '0;
                        bmi_d   = bmiw_q;
                        sat_d   = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DIVP: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PW - 1)) begin
                    bfp_d   = (|quo_nx[PW-1:W]) ? '1 : quo_nx[W-1:0];
                    bmi_d   = bmiw_q;
                    sat_d   = bsat_q | (|quo_nx[PW-1:W]);
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            cnt_q    <= '0;
            sex_q    <= 1'b0;
            weight_q <= '0;
            height_q <= '0;
            age_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            bmiw_q   <= '0;
            bsat_q   <= 1'b0;
            n_q      <= '0;
            bfp_q    <= '0;
            bmi_q    <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            sex_q    <= sex_d;
            weight_q <= weight_d;
            height_q <= height_d;
            age_q    <= age_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            bmiw_q   <= bmiw_d;
            bsat_q   <= bsat_d;
            n_q      <= n_d;
            bfp_q    <= bfp_d;
            bmi_q    <= bmi_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_bfp_calc_seq.sv
// Testbench for bfp_calc_seq: directed cases plus randomized requests checked
// against an arithmetic reference model (BFP_ROUND_EN honoured if defined).
module tb_bfp_calc_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         sex = 1'b0;
    logic [W-1:0] weight = '0;
    logic [W-1:0] height = '0;
    logic [W-1:0] age = '0;
    logic         busy, out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] bfp, bmi;
    logic         sat, err;

    int n_checks = 0;
    int n_fail   = 0;

    bfp_calc_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sex       (sex),
        .weight    (weight),
        .height    (height),
        .age       (age),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bfp       (bfp),
        .bmi       (bmi),
        .sat       (sat),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic from the formulas
    function automatic void ref_model(input bit s, input int w, input int h, input int a,
                                      output int e_bmi, output int e_bfp, output int e_sat,
                                      output int e_err, output int e_lat);
        longint q, n, p, rnd, maxv;
        maxv = (longint'(1) << W) - 1;
`ifdef BFP_ROUND_EN
        rnd = 50;
`else
        rnd = 0;
`endif
        e_err = 0; e_sat = 0;
        if (h == 0) begin
            e_err = 1; e_bmi = 0; e_bfp = 0; e_lat = 1;
            return;
        end
        q = (longint'(w) * 10000) / (longint'(h) * h);
        if (q > maxv) begin q = maxv; e_sat = 1; end
        e_bmi = int'(q);
        n = 120 * q + 23 * longint'(a) - (s ? 1620 : 540);
        if (n < 0) begin
            e_bfp = 0; e_sat = 1; e_lat = W + 18;
        end else begin
            p = (n + rnd) / 100;
            if (p > maxv) begin p = maxv; e_sat = 1; end
            e_bfp = int'(p);
            e_lat = 2 * W + 25;
        end
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) check_eq("idle_timeout", busy, 0);
    endtask

    task automatic run_req(input bit s, input int w, input int h, input int a,
                           input int hold, input bit early);
        int e_bmi, e_bfp, e_sat, e_err, e_lat;
        int edges, changed, unstable, prev_bmi, prev_bfp;
        ref_model(s, w, h, a, e_bmi, e_bfp, e_sat, e_err, e_lat);
        wait_idle();
        @(negedge clk);
        sex = s; weight = w[W-1:0]; height = h[W-1:0]; age = a[W-1:0];
        start = 1'b1; out_ready = early;
        prev_bmi = bmi; prev_bfp = bfp;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_accept", busy, 1);
        edges = 0; changed = 0;
        while (!out_valid && edges < 200) begin
            if (bmi !== prev_bmi[W-1:0] || bfp !== prev_bfp[W-1:0]) changed++;
            @(posedge clk); #1;
            edges++;
        end
        check_eq("out_hold_until_done", changed, 0);
        check_eq("latency", edges, e_lat);
        check_eq("bmi", bmi, e_bmi);
        check_eq("bfp", bfp, e_bfp);
        check_eq("sat", sat, e_sat);
        check_eq("err", err, e_err);
        unstable = 0;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                start = (i == 0);
                weight = ~weight;
                @(posedge clk); #1;
                start = 1'b0;
                if (!out_valid || !busy || bmi !== e_bmi[W-1:0] || bfp !== e_bfp[W-1:0] ||
                    sat !== e_sat[0] || err !== e_err[0]) unstable++;
            end
            check_eq("backpressure_stable", unstable, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("hs_valid_drop", out_valid, 0);
        check_eq("hs_busy_drop", busy, 0);
        @(posedge clk); #1;
        check_eq("no_queued_start", busy, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_bfp", bfp, 0);
        check_eq("rst_bmi", bmi, 0);
        check_eq("rst_sat", sat, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed cases
        run_req(1'b0, 60, 165, 30, 10, 1'b0);
        run_req(1'b1, 80, 180, 40, 2, 1'b0);
        run_req(1'b1, 40, 200, 18, 1, 1'b0);
        run_req(1'b0, 255, 50, 255, 0, 1'b0);
        run_req(1'b1, 70, 0, 25, 3, 1'b0);
        run_req(1'b0, 60, 165, 30, 0, 1'b1);

        // Reset in the middle of the BMI divide
        wait_idle();
        @(negedge clk);
        sex = 1'b0; weight = 8'd60; height = 8'd165; age = 8'd30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_bfp", bfp, 0);
        check_eq("midrst_bmi", bmi, 0);
        check_eq("midrst_sat", sat, 0);
        check_eq("midrst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b1, 80, 180, 40, 1, 1'b0);

        // Randomized requests
        for (int k = 0; k < 40; k++) begin
            int cat, h, w, a;
            cat = $urandom_range(0, 9);
            if (cat == 0)      h = 0;
            else if (cat < 3)  h = $urandom_range(1, 80);
            else               h = $urandom_range(100, 220);
            w = $urandom_range(0, 255);
            a = $urandom_range(0, 255);
            run_req(1'($urandom_range(0, 1)), w, h, a, $urandom_range(0, 3),
                    1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
